// File: rtl/dpram_pkg.sv
// Shared types for the DP-RAM read path: address/data widths and the burst reader state encoding.
package dpram_pkg;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] dpram_addr_t;
  typedef logic [DATA_W-1:0] dpram_data_t;

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_t;
endpackage

// File: rtl/hv_word_fifo.sv
// Synchronous word FIFO with registered pointers and a first-word-fall-through head.
module hv_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != FULL);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define what is valid, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dpram_burst_reader.sv
// Burst read master for the DP-RAM: issues sequential addresses under FIFO credit and streams words out.
// Optional DPRAM_READER_CHECKSUM_EN adds a per-burst XOR checksum output.
module dpram_burst_reader
  import dpram_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] raddress,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
`ifdef DPRAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_t        state;
  dpram_addr_t      addr_q;
  dpram_addr_t      issue_addr;
  logic [LEN_W-1:0] issue_left;
  logic [LEN_W-1:0] deliver_left;
  logic [RD_LAT:0]  vld_pipe;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  dpram_data_t      fifo_rdata;
  logic             accept;
  logic             accept_issue;
  logic             issue_fire;
  logic             any_issue;
  logic             push;
  logic             pop;
  logic             final_pop;

  // The first word is issued on the accept edge itself so data appears RD_LAT+1 cycles after accept.
  assign accept       = cmd_valid && cmd_ready;
  assign accept_issue = accept && (cmd_len != '0);
  assign issue_fire   = (state == RD_ISSUE) &&
                        (({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_MAX);
  assign any_issue    = accept_issue || issue_fire;
  assign issue_addr   = accept ? cmd_addr : addr_q;

  // vld_pipe[0] lines up with raddress; the tap RD_LAT stages later lines up with ram_rdata.
  assign push      = vld_pipe[RD_LAT];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (deliver_left == LEN_W'(1));
  assign final_pop = pop && (deliver_left == LEN_W'(1));
  assign out_data  = out_valid ? fifo_rdata : '0;

  hv_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .wdata  (ram_rdata),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RD_IDLE;
      cmd_ready    <= 1'b1;
      raddress     <= '0;
      addr_q       <= '0;
      issue_left   <= '0;
      deliver_left <= '0;
      vld_pipe     <= '0;
      inflight     <= '0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], any_issue};

      case ({any_issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (any_issue) begin
        raddress <= issue_addr;
        addr_q   <= issue_addr + 1'b1;
      end

      if (pop) deliver_left <= deliver_left - 1'b1;

      case (state)
        RD_IDLE: begin
          if (accept) begin
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              deliver_left <= cmd_len;
              issue_left   <= cmd_len - 1'b1;
              cmd_ready    <= 1'b0;
              state        <= (cmd_len == LEN_W'(1)) ? RD_DRAIN : RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (issue_fire) begin
            issue_left <= issue_left - 1'b1;
            if (issue_left == LEN_W'(1)) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (final_pop) begin
            state     <= RD_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

`ifdef DPRAM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    checksum <= '0;
    else if (accept) checksum <= '0;
    else if (pop)    checksum <= checksum ^ out_data;
  end
`endif
endmodule

// File: tb/tb_dpram_burst_reader.sv
// Self-checking bench for dpram_burst_reader paired with a registered-read DP-RAM emulator.
module tb_dpram_burst_reader;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [20:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [20:0] raddress;
  logic [31:0] ram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
`ifdef DPRAM_READER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dpram_burst_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .raddress (raddress),
    .ram_rdata(ram_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done)
`ifdef DPRAM_READER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  // RAM emulator: mem[a] = 32'hA000_0000 | a, one cycle registered read.
  always @(posedge clk) ram_rdata <= 32'hA000_0000 | {11'b0, raddress};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [20:0] base, input int idx);
    logic [20:0] a;
    a = base + 21'(idx);
    return 32'hA000_0000 | {11'b0, a};
  endfunction

  // Runs one burst from a negedge; mode 0: ready always, 1: 1-on/2-off, 2: random ready.
  task automatic run_burst(input logic [20:0] addr, input logic [15:0] len, input int mode,
                           input string tag);
    int          k;
    int          got;
    int          outst;
    int          max_out;
    int          budget;
    logic [31:0] xs;
    logic [20:0] span;
    k = 0; got = 0; max_out = 0; xs = 32'h0;
    budget = int'(len) * 4 + 20;
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk);
    while (got < int'(len) && k < budget) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      cmd_addr  = 21'($urandom);
      cmd_len   = 16'($urandom);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1) begin
        span  = raddress - addr;
        outst = int'(span) + 1 - got;
        if (outst > max_out) max_out = outst;
      end
      check({tag, "_no_early_done"}, done, 1'b0);
      if (out_valid && out_ready) begin
        check({tag, "_data"}, out_data, model_word(addr, got));
        check({tag, "_last"}, out_last, (got == int'(len) - 1));
        if (mode == 0) check({tag, "_cycle"}, k, got + 3);
        xs = xs ^ model_word(addr, got);
        got++;
      end
    end
    check({tag, "_word_count"}, got, int'(len));
    if (mode == 1) check({tag, "_credit_max"}, max_out, 4);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_ready_with_done"}, cmd_ready, 1'b1);
    check({tag, "_valid_after"}, out_valid, 1'b0);
`ifdef DPRAM_READER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, xs);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  int          got;
  int          k;
  logic [20:0] ra;
  logic [15:0] rl;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_raddress", raddress, 21'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_done", done, 1'b0);
`ifdef DPRAM_READER_CHECKSUM_EN
    check("rst_checksum", checksum, 32'h0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    run_burst(21'h000010, 16'd8, 0, "t1");
    run_burst(21'h1FFFFE, 16'd4, 0, "t2_wrap");
    run_burst(21'h000200, 16'd16, 1, "t3_bp");

    // Zero-length command: done only, no stream.
    cmd_valid = 1'b1;
    cmd_addr  = 21'h000055;
    cmd_len   = 16'd0;
    out_ready = 1'b1;
    check("t4_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t4_done", done, 1'b1);
    check("t4_no_valid", out_valid, 1'b0);
    check("t4_ready_kept", cmd_ready, 1'b1);
    @(negedge clk);
    check("t4_done_pulse", done, 1'b0);
    check("t4_no_valid2", out_valid, 1'b0);

    // Reset in the middle of a 10-word burst after 3 words.
    cmd_valid = 1'b1;
    cmd_addr  = 21'h000100;
    cmd_len   = 16'd10;
    out_ready = 1'b1;
    @(posedge clk);
    got = 0;
    k   = 0;
    while (got < 3 && k < 20) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      if (out_valid && out_ready) begin
        check("t5_pre_data", out_data, model_word(21'h000100, got));
        got++;
      end
    end
    check("t5_pre_count", got, 3);
    @(negedge clk);
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("t5_valid_drop", out_valid, 1'b0);
    check("t5_data_clear", out_data, 32'h0);
    check("t5_done_low", done, 1'b0);
    check("t5_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done", done, 1'b0);
      check("t5_no_valid", out_valid, 1'b0);
    end
    run_burst(21'h000040, 16'd2, 0, "t5_after");

    run_burst(21'h000000, 16'd4, 0, "t6_a");
    run_burst(21'h000001, 16'd3, 2, "t6_b");

    for (int r = 0; r < 6; r++) begin
      ra = (r % 2 == 1) ? 21'h1FFFF8 + 21'($urandom_range(0, 7)) : 21'($urandom);
      rl = 16'($urandom_range(1, 12));
      run_burst(ra, rl, 2, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
